// File: rtl/registerfile_gen2_pkg.sv
// Shared types and sizing helpers for the gen2 register file.
package registerfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 32;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/registerfile_gen2_if.sv
// Decode/writeback-facing bus of the register file: selects, write port, read data, busy.
interface registerfile_gen2_if
  import registerfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int IW = idx_w(DEPTH);

  logic [IW-1:0]    select_a;
  logic [IW-1:0]    select_b;
  logic [IW-1:0]    address;
  logic [WIDTH-1:0] data_in;
  logic             write;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             busy;

  modport master (
    output select_a, select_b, address, data_in, write,
    input  out_a, out_b, busy
  );

  modport slave (
    input  select_a, select_b, address, data_in, write,
    output out_a, out_b, busy
  );

endinterface

// File: rtl/registerfile_gen2_clear_ctl.sv
// Post-reset clear sequencer: walks every storage index once, then reports ready.
module registerfile_clear_ctl
  import registerfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  busy_o,
  output logic                  clear_en_o,
  output logic [idx_w(DEPTH)-1:0] clear_idx_o
);
  localparam int IW = idx_w(DEPTH);

  rf_state_e     state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + IW'(1);
      if (cnt_q == IW'(DEPTH - 1)) state_d = READY;
    end
  end

  // The reset edge itself must leave storage untouched, so the clear strobe is gated by reset.
  assign busy_o      = (state_q == CLEAR);
  assign clear_en_o  = (state_q == CLEAR) && !reset;
  assign clear_idx_o = cnt_q;

endmodule

// File: rtl/registerfile_gen2.sv
// DEPTH x WIDTH register file: two combinational read ports, one write port,
// hardwired zero register, optional write-to-read bypass and post-reset clear sweep.
module registerfile_gen2
  import registerfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = DEPTH - 1,
  parameter bit BYPASS   = 1'b1
) (
  input logic               clock,
  input logic               reset,
  registerfile_gen2_if.slave bus
);
  localparam int IW = idx_w(DEPTH);
  // One extra bit lets ZERO_REG == DEPTH mean "no zero register".
  localparam logic [IW:0] ZR = (IW+1)'(ZERO_REG);

  logic             busy;
  logic             clear_en;
  logic [IW-1:0]    clear_idx;
  logic             wr_en;
  logic [WIDTH-1:0] mem_q [DEPTH];

  registerfile_clear_ctl #(.DEPTH(DEPTH)) u_clear_ctl (
    .clock       (clock),
    .reset       (reset),
    .busy_o      (busy),
    .clear_en_o  (clear_en),
    .clear_idx_o (clear_idx)
  );

  function automatic logic [WIDTH-1:0] rd_mux(
    input logic [IW-1:0]    sel,
    input logic [WIDTH-1:0] stored,
    input logic             busy_s,
    input logic             wr_s,
    input logic [IW-1:0]    waddr,
    input logic [WIDTH-1:0] wdata
  );
    if (busy_s)                                  return '0;
    if ({1'b0, sel} == ZR)                       return '0;
    if (BYPASS && wr_s && (waddr == sel))        return wdata;
    return stored;
  endfunction

  // Writes are dropped while clearing, on a reset edge, and at the zero register.
  assign wr_en = bus.write && !busy && !reset && ({1'b0, bus.address} != ZR);

  always_ff @(posedge clock) begin
    if (clear_en)   mem_q[clear_idx]   <= '0;
    else if (wr_en) mem_q[bus.address] <= bus.data_in;
  end

  always_comb begin
    bus.out_a = rd_mux(bus.select_a, mem_q[bus.select_a], busy, bus.write,
                       bus.address, bus.data_in);
    bus.out_b = rd_mux(bus.select_b, mem_q[bus.select_b], busy, bus.write,
                       bus.address, bus.data_in);
  end

  assign bus.busy = busy;

endmodule

// File: tb/tb_registerfile_gen2.sv
// Directed bench: bypass and non-bypass 64x32 instances plus a 16x8 instance on a shared clock/reset.
module tb_registerfile_gen2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  registerfile_gen2_if #(.WIDTH(64), .DEPTH(32)) bus1 ();
  registerfile_gen2_if #(.WIDTH(64), .DEPTH(32)) bus0 ();
  registerfile_gen2_if #(.WIDTH(16), .DEPTH(8))  bus8 ();

  registerfile_gen2 #(.WIDTH(64), .DEPTH(32), .BYPASS(1'b1)) u_byp (
    .clock(clock), .reset(reset), .bus(bus1));
  registerfile_gen2 #(.WIDTH(64), .DEPTH(32), .BYPASS(1'b0)) u_nbp (
    .clock(clock), .reset(reset), .bus(bus0));
  registerfile_gen2 #(.WIDTH(16), .DEPTH(8)) u_w16 (
    .clock(clock), .reset(reset), .bus(bus8));

  int checks = 0;
  int errors = 0;
  int n1, n0, n8;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] ad,
                       input logic [63:0] d, input logic w);
    bus1.select_a = sa; bus1.select_b = sb; bus1.address = ad; bus1.data_in = d; bus1.write = w;
    bus0.select_a = sa; bus0.select_b = sb; bus0.address = ad; bus0.data_in = d; bus0.write = w;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic count_sweep;
    n1 = 0; n0 = 0; n8 = 0;
    for (int e = 1; e <= 40; e++) begin
      tick;
      if (!bus1.busy && n1 == 0) n1 = e;
      if (!bus0.busy && n0 == 0) n0 = e;
      if (!bus8.busy && n8 == 0) n8 = e;
      if (!bus1.busy) begin
        bus1.write = 1'b0;
        bus0.write = 1'b0;
      end
      if (e == 5) chk("sweep_read_masked", bus1.out_a, 64'h0);
    end
  endtask

  initial begin
    drive(5'd0, 5'd0, 5'd0, 64'h0, 1'b0);
    bus8.select_a = '0; bus8.select_b = '0; bus8.address = '0;
    bus8.data_in = '0;  bus8.write = 1'b0;
    reset = 1'b1;
    tick; tick;
    chk("rst_busy_byp", {63'h0, bus1.busy}, 64'h1);
    chk("rst_busy_nbp", {63'h0, bus0.busy}, 64'h1);
    chk("rst_busy_w16", {63'h0, bus8.busy}, 64'h1);
    chk("rst_out_a", bus1.out_a, 64'h0);
    chk("rst_out_b", bus1.out_b, 64'h0);
    chk("rst_out_w16", {48'h0, bus8.out_a}, 64'h0);

    // Release with a write to r3 pending throughout the sweep; it must be dropped.
    drive(5'd3, 5'd3, 5'd3, 64'hAA, 1'b1);
    reset = 1'b0;
    count_sweep;
    chk("sweep_len_byp", 64'(n1), 64'd32);
    chk("sweep_len_nbp", 64'(n0), 64'd32);
    chk("sweep_len_w16", 64'(n8), 64'd8);

    drive(5'd0, 5'd0, 5'd0, 64'h0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      bus1.select_a = 5'(i);
      bus1.select_b = 5'(31 - i);
      #1;
      chk("clr_a", bus1.out_a, 64'h0);
      chk("clr_b", bus1.out_b, 64'h0);
    end
    bus0.select_a = 5'd3;
    #1;
    chk("drop_r3_nbp", bus0.out_a, 64'h0);
    for (int i = 0; i < 8; i++) begin
      bus8.select_a = 3'(i);
      #1;
      chk("clr_w16", {48'h0, bus8.out_a}, 64'h0);
    end

    drive(5'd0, 5'd0, 5'd5, 64'hDEAD_BEEF_0123_4567, 1'b1);
    tick;
    drive(5'd5, 5'd6, 5'd0, 64'h0, 1'b0);
    #1;
    chk("r5_a_byp", bus1.out_a, 64'hDEAD_BEEF_0123_4567);
    chk("r6_b_byp", bus1.out_b, 64'h0);
    chk("r5_a_nbp", bus0.out_a, 64'hDEAD_BEEF_0123_4567);

    drive(5'd31, 5'd5, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    #1;
    chk("zr_bypass_blocked", bus1.out_a, 64'h0);
    tick;
    drive(5'd31, 5'd5, 5'd0, 64'h0, 1'b0);
    #1;
    chk("zr_a_byp", bus1.out_a, 64'h0);
    chk("zr_a_nbp", bus0.out_a, 64'h0);
    chk("zr_r5_kept", bus1.out_b, 64'hDEAD_BEEF_0123_4567);
    bus1.select_b = 5'd30;
    #1;
    chk("zr_r30_kept", bus1.out_b, 64'h0);

    drive(5'd0, 5'd0, 5'd7, 64'h55, 1'b1);
    tick;
    drive(5'd7, 5'd7, 5'd7, 64'h1234, 1'b1);
    #1;
    chk("bypass_a", bus1.out_a, 64'h1234);
    chk("bypass_b", bus1.out_b, 64'h1234);
    chk("nobypass_a", bus0.out_a, 64'h55);
    chk("nobypass_b", bus0.out_b, 64'h55);
    tick;
    drive(5'd7, 5'd7, 5'd0, 64'h0, 1'b0);
    #1;
    chk("nobypass_after", bus0.out_a, 64'h1234);
    chk("bypass_after", bus1.out_a, 64'h1234);

    bus8.address = 3'd2; bus8.data_in = 16'h1234; bus8.write = 1'b1;
    tick;
    bus8.write = 1'b0; bus8.select_a = 3'd2;
    #1;
    chk("w16_r2", {48'h0, bus8.out_a}, 64'h1234);
    bus8.address = 3'd7; bus8.data_in = 16'hBEEF; bus8.write = 1'b1;
    tick;
    bus8.write = 1'b0; bus8.select_a = 3'd7; bus8.select_b = 3'd2;
    #1;
    chk("w16_zr", {48'h0, bus8.out_a}, 64'h0);
    chk("w16_r2_kept", {48'h0, bus8.out_b}, 64'h1234);

    // Reset in READY with a simultaneous write, then a reset pulse mid-sweep.
    drive(5'd5, 5'd5, 5'd5, 64'hCAFE, 1'b1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drive(5'd5, 5'd5, 5'd0, 64'h0, 1'b0);
    chk("ready_rst_busy", {63'h0, bus1.busy}, 64'h1);
    chk("ready_rst_out", bus1.out_a, 64'h0);
    for (int e = 0; e < 10; e++) tick;
    chk("mid_sweep_busy", {63'h0, bus1.busy}, 64'h1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_busy", {63'h0, bus1.busy}, 64'h1);
    count_sweep;
    chk("resweep_len_byp", 64'(n1), 64'd32);
    chk("resweep_len_nbp", 64'(n0), 64'd32);
    chk("resweep_len_w16", 64'(n8), 64'd8);
    drive(5'd5, 5'd7, 5'd0, 64'h0, 1'b0);
    #1;
    chk("resweep_r5", bus1.out_a, 64'h0);
    chk("resweep_r7", bus1.out_b, 64'h0);
    bus8.select_a = 3'd2;
    #1;
    chk("resweep_w16_r2", {48'h0, bus8.out_a}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
